prog_counter_stack: RTL and testbench



---
 rtl/prog_counter_stack_if.sv | 26 ++
 rtl/prog_counter_stack.sv | 75 +++++++
 tb/tb_prog_counter_stack.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/prog_counter_stack_if.sv
// Control/status bundle between the control unit (master) and the program counter (slave).
interface prog_counter_stack_if #(
    parameter int N = 10
);
    logic         PC_LD;
    logic         PC_INC;
    logic [1:0]   PC_SEL;
    logic [N-1:0] DIN;
    logic         PUSH;
    logic         POP;
    logic [N-1:0] PC_COUNT;
    logic [N-1:0] STK_TOP;
    logic         STK_EMPTY;
    logic         STK_FULL;
    logic         STK_ERR;

    modport master (
        output PC_LD, PC_INC, PC_SEL, DIN, PUSH, POP,
        input  PC_COUNT, STK_TOP, STK_EMPTY, STK_FULL, STK_ERR
    );

    modport slave (
        input  PC_LD, PC_INC, PC_SEL, DIN, PUSH, POP,
        output PC_COUNT, STK_TOP, STK_EMPTY, STK_FULL, STK_ERR
    );
endinterface

// File: rtl/prog_counter_stack.sv
// RAT CPU program counter with a hardware return-address stack and selectable load source.
module prog_counter_stack #(
    parameter int           N        = 10,
    parameter int           DEPTH    = 8,
    parameter logic [N-1:0] INTR_VEC = '1
) (
    input  logic                      CLK,
    input  logic                      RST,
    prog_counter_stack_if.slave       bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  pc;
    logic [N-1:0]  pc_plus1;
    logic [CW-1:0] count;
    logic          err;
    logic [N-1:0]  stack [DEPTH];

    logic          empty;
    logic          full;
    logic [N-1:0]  top;
    logic          push_ok;
    logic          pop_ok;
    logic          misuse;

    assign pc_plus1 = pc + N'(1);
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign top      = empty ? '0 : stack[AW'(count - CW'(1))];

    // A simultaneous PUSH and POP is treated as misuse and neither takes effect.
    assign push_ok  = bus.PUSH && !bus.POP && !full;
    assign pop_ok   = bus.POP && !bus.PUSH && !empty;
    assign misuse   = (bus.PUSH && bus.POP) || (bus.PUSH && full) || (bus.POP && empty);

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc    <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (bus.PC_LD) begin
                case (bus.PC_SEL)
                    2'd0:    pc <= bus.DIN;
                    2'd1:    pc <= top;
                    2'd2:    pc <= INTR_VEC;
                    default: pc <= pc;
                endcase
            end else if (bus.PC_INC) begin
                pc <= pc_plus1;
            end

            if (push_ok)
                count <= count + CW'(1);
            else if (pop_ok)
                count <= count - CW'(1);

            if (misuse)
                err <= 1'b1;
        end
    end

    // Entry storage is not reset; count alone decides which entries are valid.
    always_ff @(posedge CLK) begin
        if (!RST && push_ok)
            stack[AW'(count)] <= pc_plus1;
    end

    assign bus.PC_COUNT  = pc;
    assign bus.STK_TOP   = top;
    assign bus.STK_EMPTY = empty;
    assign bus.STK_FULL  = full;
    assign bus.STK_ERR   = err;
endmodule

// File: tb/tb_prog_counter_stack.sv
// Directed self-checking bench for prog_counter_stack (N=10, DEPTH=4).
module tb_prog_counter_stack;
    logic clk;
    logic rst;
    int   total;
    int   fails;

    prog_counter_stack_if #(.N(10)) bus ();

    prog_counter_stack #(.N(10), .DEPTH(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of controls, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic ld, input logic inc, input logic [1:0] sel,
                        input logic [9:0] din, input logic push, input logic pop);
        rst        = r;
        bus.PC_LD  = ld;
        bus.PC_INC = inc;
        bus.PC_SEL = sel;
        bus.DIN    = din;
        bus.PUSH   = push;
        bus.POP    = pop;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.PC_LD  = 1'b0;
        bus.PC_INC = 1'b0;
        bus.PUSH   = 1'b0;
        bus.POP    = 1'b0;
    endtask

    initial begin
        total = 0;
        fails = 0;
        rst = 1'b0;
        bus.PC_LD = 1'b0; bus.PC_INC = 1'b0; bus.PC_SEL = 2'd0;
        bus.DIN = '0; bus.PUSH = 1'b0; bus.POP = 1'b0;
        @(negedge clk);

        // Reset state
        step(1, 0, 0, 0, 10'h000, 0, 0);
        check("rst_pc",    bus.PC_COUNT, 32'h0);
        check("rst_empty", bus.STK_EMPTY, 32'h1);
        check("rst_full",  bus.STK_FULL, 32'h0);
        check("rst_err",   bus.STK_ERR, 32'h0);
        check("rst_top",   bus.STK_TOP, 32'h0);

        // Increment
        step(0, 0, 1, 0, 10'h000, 0, 0); check("inc1", bus.PC_COUNT, 32'h1);
        step(0, 0, 1, 0, 10'h000, 0, 0); check("inc2", bus.PC_COUNT, 32'h2);
        step(0, 0, 1, 0, 10'h000, 0, 0); check("inc3", bus.PC_COUNT, 32'h3);
        check("inc_empty", bus.STK_EMPTY, 32'h1);
        check("inc_top",   bus.STK_TOP, 32'h0);

        // Load has priority over increment, then wrap
        step(0, 1, 1, 0, 10'h3FF, 0, 0); check("ld_3ff", bus.PC_COUNT, 32'h3FF);
        step(0, 0, 1, 0, 10'h000, 0, 0); check("wrap",   bus.PC_COUNT, 32'h0);

        // CALL then immediate RET
        step(0, 1, 0, 0, 10'h020, 0, 0); check("ld_020", bus.PC_COUNT, 32'h020);
        step(0, 1, 0, 0, 10'h100, 1, 0);
        check("call_pc",  bus.PC_COUNT, 32'h100);
        check("call_top", bus.STK_TOP, 32'h021);
        check("call_nempty", bus.STK_EMPTY, 32'h0);
        step(0, 1, 0, 1, 10'h000, 0, 1);
        check("ret_pc",    bus.PC_COUNT, 32'h021);
        check("ret_empty", bus.STK_EMPTY, 32'h1);
        check("ret_err",   bus.STK_ERR, 32'h0);

        // Interrupt entry and return; reserved select holds PC despite PC_INC
        step(0, 1, 0, 0, 10'h055, 0, 0);
        step(0, 1, 0, 2, 10'h000, 1, 0);
        check("intr_pc",  bus.PC_COUNT, 32'h3FF);
        check("intr_top", bus.STK_TOP, 32'h056);
        step(0, 1, 0, 1, 10'h000, 0, 1);
        check("reti_pc", bus.PC_COUNT, 32'h056);
        step(0, 1, 1, 3, 10'h000, 0, 0);
        check("sel3_hold", bus.PC_COUNT, 32'h056);

        // Five CALLs into a 4-deep stack
        step(0, 1, 0, 0, 10'h200, 1, 0);
        step(0, 1, 0, 0, 10'h210, 1, 0);
        step(0, 1, 0, 0, 10'h220, 1, 0);
        check("call3_full", bus.STK_FULL, 32'h0);
        step(0, 1, 0, 0, 10'h230, 1, 0);
        check("call4_full", bus.STK_FULL, 32'h1);
        check("call4_top",  bus.STK_TOP, 32'h221);
        check("call4_err",  bus.STK_ERR, 32'h0);
        step(0, 1, 0, 0, 10'h240, 1, 0);
        check("call5_pc",   bus.PC_COUNT, 32'h240);
        check("call5_top",  bus.STK_TOP, 32'h221);
        check("call5_err",  bus.STK_ERR, 32'h1);
        check("call5_full", bus.STK_FULL, 32'h1);
        step(0, 1, 0, 1, 10'h000, 0, 1);
        check("ret_full_pc",  bus.PC_COUNT, 32'h221);
        check("ret_full_top", bus.STK_TOP, 32'h211);
        check("ret_full_nf",  bus.STK_FULL, 32'h0);
        check("err_sticky",   bus.STK_ERR, 32'h1);

        // RET on an empty stack
        step(1, 0, 0, 0, 10'h000, 0, 0);
        check("rst2_err", bus.STK_ERR, 32'h0);
        step(0, 1, 0, 0, 10'h123, 0, 0);
        step(0, 1, 0, 1, 10'h000, 0, 1);
        check("ret_empty_pc",  bus.PC_COUNT, 32'h0);
        check("ret_empty_err", bus.STK_ERR, 32'h1);
        check("ret_empty_e",   bus.STK_EMPTY, 32'h1);

        // PUSH+POP in one cycle with two entries
        step(1, 0, 0, 0, 10'h000, 0, 0);
        step(0, 0, 1, 0, 10'h000, 1, 0);
        step(0, 0, 1, 0, 10'h000, 1, 0);
        check("pp_pre_top", bus.STK_TOP, 32'h2);
        step(0, 1, 0, 1, 10'h000, 1, 1);
        check("pp_pc",  bus.PC_COUNT, 32'h2);
        check("pp_top", bus.STK_TOP, 32'h2);
        check("pp_err", bus.STK_ERR, 32'h1);
        step(0, 0, 0, 0, 10'h000, 0, 1);
        check("pp_pop1_top", bus.STK_TOP, 32'h1);
        step(0, 0, 0, 0, 10'h000, 0, 1);
        check("pp_pop2_empty", bus.STK_EMPTY, 32'h1);

        // RST during a CALL
        step(0, 1, 0, 0, 10'h080, 0, 0);
        step(1, 1, 0, 0, 10'h100, 1, 0);
        check("rstcall_pc",    bus.PC_COUNT, 32'h0);
        check("rstcall_empty", bus.STK_EMPTY, 32'h1);
        check("rstcall_top",   bus.STK_TOP, 32'h0);
        check("rstcall_err",   bus.STK_ERR, 32'h0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
